veda_loader: RTL and testbench

- Program/data writer for the 32x32 Veda memory; the write-side counterpart of the CPU fetch path, which only reads.
- Accepts a byte stream on a valid/ready handshake and packs each group of 4 bytes into a 32-bit word, first byte into [31:24] (big-endian).
- Writes the words to consecutive memory addresses through the Veda port (reset, write_enable, addr, data_in, mode).
- Holds the CPU in stall while loading.

---
 rtl/veda_loader.sv | 150 +++++++++++++++
 tb/tb_veda_loader.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/veda_loader.sv
// veda_loader: packs a big-endian byte stream into 32-bit words and writes them to
// consecutive Veda addresses while holding the CPU. Define VEDA_LOADER_VERIFY_EN for readback checking.
module veda_loader #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32,
   parameter int BYTE_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   word_count,
   input  logic              in_valid,
   input  logic [BYTE_W-1:0] in_data,
   output logic              in_ready,
   output logic              mem_we,
   output logic              mem_mode,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              cpu_hold,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W:0]   words_written,
   output logic              verify_err
);

   localparam int BYTES = DATA_W / BYTE_W;
   localparam int IDX_W = $clog2(BYTES);
   localparam int CNT_W = ADDR_W + 1;
   localparam logic [CNT_W-1:0] MAX_WORDS = CNT_W'(1) << ADDR_W;

   typedef enum logic [2:0] {
      IDLE,
      COLLECT,
      WRITE,
`ifdef VEDA_LOADER_VERIFY_EN
      VERIFY_RD,
      VERIFY_CMP,
`endif
      DONE
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [CNT_W-1:0]    rem_q, rem_d;
   logic [CNT_W-1:0]    ww_q, ww_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [DATA_W-1:0]   word_q, word_d;
   logic                err_q, err_d;

   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
      state_d = state_q;
      addr_d  = addr_q;
      rem_d   = rem_q;
      ww_d    = ww_q;
      idx_d   = idx_q;
      word_d  = word_q;
      err_d   = err_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               ww_d  = '0;
               err_d = 1'b0;
               if (word_count == '0) begin
                  state_d = DONE;
               end else begin
                  addr_d  = base_addr;
                  rem_d   = (word_count > MAX_WORDS) ? MAX_WORDS : word_count;
                  idx_d   = '0;
                  state_d = COLLECT;
               end
            end
         end
         COLLECT: begin
            if (in_valid) begin
               // Byte k lands in the k-th most significant byte lane.
               word_d[BYTE_W*(BYTES-1-int'(idx_q)) +: BYTE_W] = in_data;
               idx_d = idx_q + IDX_W'(1);
               if (idx_q == IDX_W'(BYTES-1)) state_d = WRITE;
            end
         end
         WRITE: begin
            ww_d   = ww_q + CNT_W'(1);
            addr_d = addr_q + ADDR_W'(1);
            rem_d  = rem_q - CNT_W'(1);
`ifdef VEDA_LOADER_VERIFY_EN
            state_d = VERIFY_RD;
`else
            state_d = (rem_q == CNT_W'(1)) ? DONE : COLLECT;
`endif
         end
`ifdef VEDA_LOADER_VERIFY_EN
         VERIFY_RD:  state_d = VERIFY_CMP;
         VERIFY_CMP: begin
            if (mem_rdata != word_q) err_d = 1'b1;
            state_d = (rem_q == '0) ? DONE : COLLECT;
         end
`endif
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         addr_q  <= '0;
         rem_q   <= '0;
         ww_q    <= '0;
         idx_q   <= '0;
         word_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking so every flop samples the pre-edge values of the others.
         state_q <= state_d;
         addr_q  <= addr_d;
         rem_q   <= rem_d;
         ww_q    <= ww_d;
         idx_q   <= idx_d;
         word_q  <= word_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      mem_addr = addr_q;
`ifdef VEDA_LOADER_VERIFY_EN
      // The counter has already advanced past the word being read back.
      if (state_q == VERIFY_RD || state_q == VERIFY_CMP) mem_addr = addr_q - ADDR_W'(1);
`endif
   end

`ifndef VEDA_LOADER_VERIFY_EN
   logic rdata_unused;
   assign rdata_unused = ^mem_rdata;
`endif

   assign in_ready      = (state_q == COLLECT);
   assign mem_we        = (state_q == WRITE);
   assign mem_mode      = ~mem_we;
   assign mem_wdata     = word_q;
   assign busy          = (state_q != IDLE) && (state_q != DONE);
   assign cpu_hold      = busy;
   assign done          = (state_q == DONE);
   assign words_written = ww_q;
   assign verify_err    = err_q;

endmodule

// File: tb/tb_veda_loader.sv
// tb_veda_loader: randomized byte-stream loads against a word-level reference model;
// expected writes are queued at issue time and popped by an independent monitor.
module tb_veda_loader;

   logic        clk = 1'b0;
   logic        reset, start, in_valid, in_ready;
   logic [4:0]  base_addr, mem_addr;
   logic [5:0]  word_count, words_written;
   logic [7:0]  in_data;
   logic        mem_we, mem_mode, cpu_hold, busy, done, verify_err;
   logic [31:0] mem_wdata, mem_rdata;

   typedef struct packed {
      logic [4:0]  addr;
      logic [31:0] data;
   } wr_t;

   wr_t         exp_wr_q[$];
   int          exp_done_q[$];
   int          errors = 0;
   int          checks = 0;
   logic [31:0] tb_mem [32];
   bit          force_bad = 1'b0;
   wr_t         got_e;
   int          got_n;

   always #5 clk = ~clk;

   assign mem_rdata = force_bad ? 32'h0 : tb_mem[mem_addr];
   always @(posedge clk) if (mem_we) tb_mem[mem_addr] <= mem_wdata;

   veda_loader dut (
      .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
      .word_count(word_count), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .mem_we(mem_we), .mem_mode(mem_mode),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .cpu_hold(cpu_hold), .busy(busy), .done(done),
      .words_written(words_written), .verify_err(verify_err)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: pops the scoreboard whenever the DUT writes or signals completion.
   initial forever begin
      @(negedge clk);
      if (reset) begin
         check("mode_vs_we", mem_mode, !mem_we);
         check("hold_eq_busy", cpu_hold, busy);
         if (mem_we) begin
            if (exp_wr_q.size() == 0) begin
               check("unexpected_write", 1, 0);
            end else begin
               got_e = exp_wr_q.pop_front();
               check("wr_addr", mem_addr, got_e.addr);
               check("wr_data", mem_wdata, got_e.data);
               check("wr_in_ready", in_ready, 0);
            end
         end
         if (done) begin
            if (exp_done_q.size() == 0) begin
               check("unexpected_done", 1, 0);
            end else begin
               got_n = exp_done_q.pop_front();
               check("done_words", words_written, got_n);
               check("done_writes_left", exp_wr_q.size(), 0);
               check("done_busy", busy, 0);
            end
         end
      end
   end

   task automatic check_reset_vals();
      check("rst_in_ready", in_ready, 0);
      check("rst_mem_we", mem_we, 0);
      check("rst_mem_mode", mem_mode, 1);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_wdata", mem_wdata, 0);
      check("rst_cpu_hold", cpu_hold, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_words", words_written, 0);
      check("rst_verify_err", verify_err, 0);
   endtask

   // vmode: 0 = always valid, 1 = toggle each cycle, 2 = random gaps.
   task automatic run_load(input logic [4:0] base, input logic [5:0] wc, input int vmode,
                           input logic [31:0] fixed, input bit use_fixed, input bit stray);
      logic [7:0] bytes[$];
      int n, idx, cyc, we_pend;
      bit v, acc, saw_done;
      n = (wc > 6'd32) ? 32 : int'(wc);
      for (int w = 0; w < n; w++) begin
         logic [7:0] b[4];
         wr_t e;
         for (int k = 0; k < 4; k++) b[k] = 8'($urandom);
         if (use_fixed && w == 0) {b[0], b[1], b[2], b[3]} = fixed;
         for (int k = 0; k < 4; k++) bytes.push_back(b[k]);
         e.addr = 5'((int'(base) + w) % 32);
         e.data = {b[0], b[1], b[2], b[3]};
         exp_wr_q.push_back(e);
      end
      exp_done_q.push_back(n);
      @(negedge clk);
      start = 1'b1; base_addr = base; word_count = wc;
      @(negedge clk);
      start = 1'b0;
      idx = 0; cyc = 0; we_pend = 0; saw_done = 1'b0;
      while ((idx < 4*n || we_pend != 0) && cyc < 3000) begin
         saw_done |= done;
         if (!saw_done) check("busy_during_load", busy, 1);
         if (we_pend == 1) begin
            check("we_latency", mem_we, 1);
            we_pend = 2;
         end else if (we_pend == 2) begin
            check("we_single_cycle", mem_we, 0);
            we_pend = 0;
         end
         case (vmode)
            0:       v = 1'b1;
            1:       v = (cyc % 2 == 0);
            default: v = ($urandom_range(0, 3) != 0);
         endcase
         in_valid = v && (idx < 4*n);
         in_data  = in_valid ? bytes[idx] : 8'($urandom);
         if (stray && cyc == 5) begin
            start = 1'b1; base_addr = base ^ 5'h15; word_count = 6'd3;
         end else begin
            start = 1'b0;
         end
         acc = in_valid && in_ready;
         @(posedge clk);
         if (acc) begin
            idx++;
            if (idx % 4 == 0) we_pend = 1;
         end
         @(negedge clk);
         cyc++;
      end
      in_valid = 1'b0; start = 1'b0;
      if (cyc >= 3000) check("feed_timeout", 0, 1);
      cyc = 0;
      while (!saw_done && cyc < 50) begin
         saw_done |= done;
         if (!saw_done) begin
            @(negedge clk);
            cyc++;
         end
      end
      check("done_seen", saw_done, 1);
      if (done) @(negedge clk);
      check("post_done_pulse", done, 0);
      check("post_hold", cpu_hold, 0);
      check("post_words_hold", words_written, n);
   endtask

   initial begin
      reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0;
      base_addr = '0; word_count = '0;
      repeat (3) @(negedge clk);
      check_reset_vals();
      reset = 1'b1;

      run_load(5'd3, 6'd1, 0, 32'h3BFD0001, 1'b1, 1'b0);
      check("single_verify_err", verify_err, 0);
      run_load(5'd29, 6'd4, 0, 32'h0, 1'b0, 1'b0);
      run_load(5'd10, 6'd3, 1, 32'h0, 1'b0, 1'b0);

      // Zero-length load: done next cycle, nothing written, never busy.
      @(negedge clk);
      start = 1'b1; base_addr = 5'd17; word_count = 6'd0;
      exp_done_q.push_back(0);
      @(negedge clk);
      start = 1'b0;
      check("zero_done", done, 1);
      check("zero_busy", busy, 0);
      @(negedge clk);
      check("zero_done_once", done, 0);
      check("zero_busy_after", busy, 0);

      // Reset two bytes into a word: the partial word must never be written.
      @(negedge clk);
      start = 1'b1; base_addr = 5'd9; word_count = 6'd2;
      @(negedge clk);
      start = 1'b0; in_valid = 1'b1; in_data = 8'hA5;
      @(negedge clk);
      in_data = 8'h5A;
      @(negedge clk);
      in_valid = 1'b0;
      check("abort_busy", busy, 1);
      reset = 1'b0;
      @(negedge clk);
      check_reset_vals();
      reset = 1'b1;

      run_load(5'd7, 6'd2, 2, 32'h0, 1'b0, 1'b1);
      run_load(5'd5, 6'd40, 2, 32'h0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++)
         run_load(5'($urandom), 6'($urandom_range(1, 8)), $urandom_range(0, 2), 32'h0, 1'b0, 1'b0);

`ifdef VEDA_LOADER_VERIFY_EN
      force_bad = 1'b1;
      run_load(5'd12, 6'd1, 0, 32'h5000000C, 1'b1, 1'b0);
      force_bad = 1'b0;
      check("verify_err_set", verify_err, 1);
      repeat (3) @(negedge clk);
      check("verify_err_sticky", verify_err, 1);
      run_load(5'd12, 6'd1, 0, 32'h5000000C, 1'b1, 1'b0);
      check("verify_err_clear", verify_err, 0);
`endif

      repeat (3) @(negedge clk);
      check("final_writes_left", exp_wr_q.size(), 0);
      check("final_dones_left", exp_done_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

endmodule
